// File: rtl/nbit_register.sv
// rtl/nbit_register.sv - N-bit load-enable register with asynchronous reset
// Optional feature: define NBIT_REGISTER_PARITY_EN to add the registered even-parity output.
module nbit_register #(
  parameter int unsigned  N           = 8,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] d,
`ifdef NBIT_REGISTER_PARITY_EN
  output logic         parity,
`endif
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (enable) begin
      q <= d;
    end
  end

`ifdef NBIT_REGISTER_PARITY_EN
  // Parity is computed from d so it lands on the same edge as q, keeping both purely registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity <= ^RESET_VALUE;
    end else if (enable) begin
      parity <= ^d;
    end
  end
`endif

endmodule

// File: tb/tb_nbit_register.sv
// tb/tb_nbit_register.sv - scoreboard bench for nbit_register with randomized traffic
module tb_nbit_register;
  localparam int unsigned  N  = 8;
  localparam logic [N-1:0] RV = '0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [N-1:0] d = '0;
  logic [N-1:0] q;
`ifdef NBIT_REGISTER_PARITY_EN
  logic         parity;
`endif

  int tests = 0;
  int fails = 0;
  logic [N-1:0] model_q = RV;
  logic [N-1:0] exp_q[$];

  nbit_register #(.N(N), .RESET_VALUE(RV)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .d      (d),
`ifdef NBIT_REGISTER_PARITY_EN
    .parity (parity),
`endif
    .q      (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every falling edge, the response to the preceding rising edge is compared.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [N-1:0] e;
      e = exp_q.pop_front();
      check("q", q, e);
`ifdef NBIT_REGISTER_PARITY_EN
      check("parity", parity, $countones(e) % 2);
`endif
    end
  end

  // One clock of stimulus; the reference model is updated at the edge and its result queued.
  task automatic step(input logic r, input logic e, input logic [N-1:0] v, input bit wiggle);
    @(negedge clk);
    #1;
    reset = r; enable = e; d = v;
    if (r) begin
      model_q = RV;
      #1;
      check("async_reset", q, RV);
    end else if (wiggle && !e) begin
      for (int k = 0; k < 3; k++) begin
        #1;
        d = N'($urandom);
        check("hold_on_d_toggle", q, model_q);
      end
    end
    @(posedge clk);
    if (r) model_q = RV;
    else if (e) model_q = v;
    exp_q.push_back(model_q);
  endtask

  // Reset pulse that starts and ends between two rising edges.
  task automatic short_pulse();
    @(negedge clk);
    #1;
    enable = 1'b1; d = 8'h3C; reset = 1'b1;
    #1;
    check("pulse_q_immediate", q, RV);
    #1;
    check("pulse_q_held", q, RV);
    reset = 1'b0; enable = 1'b0;
    model_q = RV;
    @(posedge clk);
    exp_q.push_back(model_q);
  endtask

  initial begin
    logic r, e;
    #1;
    check("reset_state", q, RV);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hAA, 1'b1);
    step(1'b0, 1'b1, 8'hAB, 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    short_pulse();
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 8'hC3, 1'b0);
    step(1'b1, 1'b1, 8'h96, 1'b0);
    step(1'b0, 1'b1, 8'h81, 1'b0);
    step(1'b0, 1'b1, 8'h07, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 19) == 0);
      e = $urandom_range(0, 1) == 1;
      step(r, e, N'($urandom), $urandom_range(0, 1) == 1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nbit_register.md
NBIT_REGISTER -- requirements
Module: nbit_register

Interface
REQ-001 Parameter N, default 8: data width in bits; legal range 1..64.
REQ-002 Parameter RESET_VALUE, default all-zeros, N bits wide: value loaded into q by reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  load enable; active-high.
REQ-006 d  input  N  data to load.
REQ-007 q  output  N  registered data; driven directly from flops, no combinational path from any input.
REQ-008 parity  output  1  registered even parity of q; present only when NBIT_REGISTER_PARITY_EN is defined.

Function
REQ-009 On a rising clk edge with reset low and enable high, q SHALL take the value of d sampled at that edge; latency one cycle.
REQ-010 On a rising clk edge with reset low and enable low, q SHALL hold its previous value.
REQ-011 d SHALL be ignored whenever enable is low, including any d toggles between edges.
REQ-012 Back-to-back enabled cycles SHALL load a new d value on every edge, with no bubble.
REQ-013 q SHALL change only on a rising clk edge or on reset assertion, never on d or enable changes alone.
REQ-014 All N bits SHALL load and hold independently; no bit masking, truncation or sign handling.
REQ-015 X/Z on d while enable is low SHALL NOT propagate to q.

Reset
REQ-016 Reset assertion SHALL force q to RESET_VALUE immediately, without waiting for a clk edge.
REQ-017 While reset is high, q SHALL stay at RESET_VALUE regardless of clk, enable and d.
REQ-018 Reset SHALL take priority over enable on any edge where both are high.
REQ-019 After reset deasserts, the first rising clk edge with enable high SHALL load d normally.
REQ-020 Reset asserted mid-operation SHALL discard the held value; no prior data survives reset.

Configuration
REQ-021 Macro NBIT_REGISTER_PARITY_EN SHALL control the parity feature.
REQ-022 With NBIT_REGISTER_PARITY_EN defined, the parity port SHALL exist and SHALL equal the XOR of all bits of q, updated on the same edge as q.
REQ-023 Under reset, parity SHALL equal the XOR of RESET_VALUE bits.
REQ-024 Without NBIT_REGISTER_PARITY_EN, the parity port and its flop SHALL be absent, and the behaviour of q SHALL be identical to the build with the macro defined.

Verification
REQ-025 Bench SHALL cover: reset high with d=0x11 and enable=1 for 3 edges -> q=0x00 throughout.
REQ-026 Bench SHALL cover: reset low, enable=1, d=0xFF at an edge -> q=0xFF after that edge.
REQ-027 Bench SHALL cover: enable=0, d=0xAA for 3 edges after q=0xFF -> q stays 0xFF.
REQ-028 Bench SHALL cover: enable=1 with d=0xAB, then 0x5A, then 0x00 on consecutive edges -> q=0xAB, 0x5A, 0x00 on those edges.
REQ-029 Bench SHALL cover: q=0xFF, reset pulsed high between clk edges -> q=0x00 before the next edge; q=0x00 for the whole pulse even with enable=1.
REQ-030 Bench SHALL cover, with NBIT_REGISTER_PARITY_EN defined: load 0x07 -> parity=1; load 0x03 -> parity=0.
